// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter (core vs. DMA burst port).
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dmem_arb_state_e;

  localparam int         ADR_W_DEF = 12;
  localparam int         DATA_W    = 32;
  localparam logic [3:0] WE_FULL   = 4'b1111;

endpackage

// File: rtl/dmem_starve_ctr.sv
// Saturating count of consecutive cycles the DMA lost arbitration; o_limit flags
// that the next DMA beat must be forced.
module dmem_starve_ctr #(
  parameter int MAX = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_limit
);

  logic [7:0] r_cnt;

  // Clear wins over increment; the count never wraps.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cnt <= 8'd0;
    end else if (i_clr) begin
      r_cnt <= 8'd0;
    end else if (i_inc && (r_cnt != 8'hFF)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_limit = (r_cnt >= 8'(MAX));

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-ported data memory between the MEM stage and a DMA burst port.
// Define DMEM_ARB_STARVE_EN to add the starvation counter that forces DMA beats.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 8,
  parameter int ADR_W      = ADR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_core_ld,
  input  logic              i_core_str,
  input  logic [ADR_W-1:0]  i_core_adr,
  input  logic [DATA_W-1:0] i_core_wdata,
  input  logic [3:0]        i_core_we,
  output logic [DATA_W-1:0] o_core_rdata,
  output logic              o_core_stall,
  input  logic              i_dma_req,
  input  logic              i_dma_wr,
  input  logic [ADR_W-1:0]  i_dma_adr,
  input  logic [7:0]        i_dma_len,
  output logic              o_dma_ack,
  output logic              o_dma_beat,
  input  logic [DATA_W-1:0] i_dma_wdata,
  output logic [DATA_W-1:0] o_dma_rdata,
  output logic              o_dma_rvalid,
  output logic              o_dma_done,
  output logic [ADR_W-1:0]  o_mem_adr,
  output logic [DATA_W-1:0] o_mem_din,
  output logic [3:0]        o_mem_we,
  output logic              o_mem_ld,
  output logic              o_mem_str,
  input  logic [DATA_W-1:0] i_mem_dout
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]        r_state;
  logic [ADR_W-1:0]  r_adr;
  logic [7:0]        r_cnt;
  logic              r_wr;
  logic              r_ack;
  logic              r_done;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;

  logic w_core_act;
  logic w_run;
  logic w_dma_grant;
  logic w_core_grant;
  logic w_stall;

  assign w_core_act = i_core_ld | i_core_str;
  // The acknowledge cycle is not arbitrated, so the first beat lands one cycle after dma_ack.
  assign w_run      = (r_state == S_RUN) && !r_ack;

`ifdef DMEM_ARB_STARVE_EN
  logic w_limit;

  dmem_starve_ctr #(
    .MAX(STARVE_MAX)
  ) u_starve_ctr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (w_run & w_core_act & ~w_limit),
    .i_clr   (w_dma_grant | ~w_run),
    .o_limit (w_limit)
  );

  assign w_dma_grant = w_run && (!w_core_act || w_limit);
  assign w_stall     = w_dma_grant && w_core_act;
`else
  logic w_unused_starve;

  assign w_unused_starve = (STARVE_MAX != 0);
  assign w_dma_grant     = w_run && !w_core_act;
  assign w_stall         = 1'b0;
`endif

  assign w_core_grant = w_core_act && !w_dma_grant;

  assign o_core_rdata = i_reset ? i_mem_dout : {DATA_W{1'b0}};
  assign o_core_stall = i_reset & w_stall;
  assign o_dma_beat   = i_reset & w_dma_grant;
  assign o_dma_ack    = r_ack;
  assign o_dma_done   = r_done;
  assign o_dma_rvalid = r_rvalid;
  assign o_dma_rdata  = r_rdata;

  // Memory port mux: DMA beat, core passthrough, or all-zero when nobody is granted.
  always_comb begin
    o_mem_adr = {ADR_W{1'b0}};
    o_mem_din = {DATA_W{1'b0}};
    o_mem_we  = 4'b0000;
    o_mem_ld  = 1'b0;
    o_mem_str = 1'b0;
    if (i_reset && w_dma_grant) begin
      o_mem_adr = r_adr;
      if (r_wr) begin
        o_mem_din = i_dma_wdata;
        o_mem_we  = WE_FULL;
        o_mem_str = 1'b1;
      end else begin
        o_mem_ld  = 1'b1;
      end
    end else if (i_reset && w_core_grant) begin
      o_mem_adr = i_core_adr;
      o_mem_din = i_core_wdata;
      o_mem_we  = i_core_we;
      o_mem_ld  = i_core_ld;
      o_mem_str = i_core_str;
    end else begin
      o_mem_adr = {ADR_W{1'b0}};
      o_mem_din = {DATA_W{1'b0}};
      o_mem_we  = 4'b0000;
      o_mem_ld  = 1'b0;
      o_mem_str = 1'b0;
    end
  end

  // Burst FSM, latched burst descriptor and registered DMA-side outputs.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state  <= S_IDLE;
      r_adr    <= {ADR_W{1'b0}};
      r_cnt    <= 8'd0;
      r_wr     <= 1'b0;
      r_ack    <= 1'b0;
      r_done   <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= {DATA_W{1'b0}};
    end else begin
      r_ack    <= 1'b0;
      r_done   <= 1'b0;
      r_rvalid <= w_dma_grant && !r_wr;
      if (w_dma_grant && !r_wr) begin
        r_rdata <= i_mem_dout;
      end
      case (r_state)
        S_IDLE: begin
          if (i_dma_req) begin
            r_ack   <= 1'b1;
            r_adr   <= i_dma_adr;
            r_cnt   <= i_dma_len;
            r_wr    <= i_dma_wr;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_dma_grant) begin
            r_adr <= r_adr + {{(ADR_W-1){1'b0}}, 1'b1};
            if (r_cnt == 8'd0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural datamemory plus a burst-level
// reference model; follows the DMEM_ARB_STARVE_EN setting of the build.
module tb_dmem_arbiter;

  localparam int STARVE_MAX = 8;
  localparam int ADR_W      = 12;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        core_ld, core_str;
  logic [11:0] core_adr;
  logic [31:0] core_wdata;
  logic [3:0]  core_we;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        dma_req, dma_wr;
  logic [11:0] dma_adr;
  logic [7:0]  dma_len;
  logic        dma_ack, dma_beat;
  logic [31:0] dma_wdata, dma_rdata;
  logic        dma_rvalid, dma_done;
  logic [11:0] mem_adr;
  logic [31:0] mem_din;
  logic [3:0]  mem_we;
  logic        mem_ld, mem_str;
  logic [31:0] mem_dout;

  int n_pass;
  int n_total;

  dmem_arbiter #(.STARVE_MAX(STARVE_MAX), .ADR_W(ADR_W)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_core_ld(core_ld), .i_core_str(core_str), .i_core_adr(core_adr),
    .i_core_wdata(core_wdata), .i_core_we(core_we),
    .o_core_rdata(core_rdata), .o_core_stall(core_stall),
    .i_dma_req(dma_req), .i_dma_wr(dma_wr), .i_dma_adr(dma_adr), .i_dma_len(dma_len),
    .o_dma_ack(dma_ack), .o_dma_beat(dma_beat), .i_dma_wdata(dma_wdata),
    .o_dma_rdata(dma_rdata), .o_dma_rvalid(dma_rvalid), .o_dma_done(dma_done),
    .o_mem_adr(mem_adr), .o_mem_din(mem_din), .o_mem_we(mem_we),
    .o_mem_ld(mem_ld), .o_mem_str(mem_str), .i_mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pattern(input logic [11:0] a);
    return {8'hC3, a, ~a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Behavioural datamemory: combinational read, byte-enabled write on the rising edge.
  logic [31:0] mem   [0:4095];
  bit          mem_v [0:4095];
  assign mem_dout = mem_v[mem_adr] ? mem[mem_adr] : pattern(mem_adr);
  always @(posedge clk) begin
    if (mem_str) begin
      mem[mem_adr]   <= merge(mem_v[mem_adr] ? mem[mem_adr] : pattern(mem_adr), mem_din, mem_we);
      mem_v[mem_adr] <= 1'b1;
    end
  end

  // Expected memory image, maintained only by the reference model.
  logic [31:0] exp_mem [0:4095];
  bit          exp_v   [0:4095];

  function automatic logic [31:0] exp_word(input logic [11:0] a);
    return exp_v[a] ? exp_mem[a] : pattern(a);
  endfunction

  task automatic exp_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] we);
    exp_mem[a] = merge(exp_word(a), d, we);
    exp_v[a]   = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; core_ld = 1'b1; core_str = 1'b1; core_adr = 12'hABC;
    core_wdata = 32'h1234_5678; core_we = 4'hF; dma_req = 1'b1; dma_wr = 1'b1;
    dma_adr = 12'h003; dma_len = 8'd4; dma_wdata = 32'h5555_AAAA;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_total++;
      if ({core_stall, dma_beat, dma_ack, dma_rvalid, dma_done, mem_ld, mem_str} !== 7'b0 ||
          mem_adr !== 12'h0 || mem_din !== 32'h0 || mem_we !== 4'h0 ||
          core_rdata !== 32'h0 || dma_rdata !== 32'h0)
        $display("FAIL reset_outputs cyc=%0d got ctl=%b adr=%h din=%h we=%h crd=%h drd=%h, want all zero",
                 i, {core_stall, dma_beat, dma_ack, dma_rvalid, dma_done, mem_ld, mem_str},
                 mem_adr, mem_din, mem_we, core_rdata, dma_rdata);
      else n_pass++;
      @(posedge clk); #1;
    end
    reset = 1'b1; dma_req = 1'b0; core_ld = 1'b0; core_str = 1'b1;
    core_adr = 12'h010; core_wdata = 32'hDEADBEEF; core_we = 4'b0011;
    @(negedge clk);
    n_total++;
    if ({mem_adr, mem_din, mem_we, mem_ld, mem_str} !== {12'h010, 32'hDEADBEEF, 4'b0011, 1'b0, 1'b1})
      $display("FAIL core_mirror got adr=%h din=%h we=%b ld=%b str=%b, want 010/DEADBEEF/0011/0/1",
               mem_adr, mem_din, mem_we, mem_ld, mem_str);
    else n_pass++;
    n_total++;
    if ({core_stall, dma_beat, dma_ack, dma_rvalid, dma_done} !== 5'b0)
      $display("FAIL idle_dma_quiet got %b, want 00000",
               {core_stall, dma_beat, dma_ack, dma_rvalid, dma_done});
    else n_pass++;
    @(posedge clk); #1;
    exp_write(12'h010, 32'hDEADBEEF, 4'b0011);
    core_str = 1'b0; core_ld = 1'b1;
    @(negedge clk);
    n_total++;
    if (core_rdata !== exp_word(12'h010) || mem_ld !== 1'b1 || mem_adr !== 12'h010)
      $display("FAIL core_readback got rdata=%h ld=%b adr=%h, want %h/1/010",
               core_rdata, mem_ld, mem_adr, exp_word(12'h010));
    else n_pass++;
    @(posedge clk); #1;
    core_ld = 1'b0;
    @(negedge clk);
    n_total++;
    if ({mem_adr, mem_din, mem_we, mem_ld, mem_str} !== 50'b0)
      $display("FAIL no_grant_zero got adr=%h din=%h we=%b ld=%b str=%b, want all zero",
               mem_adr, mem_din, mem_we, mem_ld, mem_str);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  // One burst from request to the idle cycle after dma_done, checked every cycle.
  // mode: 0 no core traffic, 1 core load every cycle, 2 random core loads,
  //       3 core loads for the first 40 cycles then none.
  task automatic run_burst(input bit wr, input logic [11:0] adr, input logic [7:0] len,
                           input int mode, input string tag);
    int          remaining, streak, budget, nbeats;
    logic [11:0] nadr;
    bit          ack_cyc, done_pend, finished, pend_rv, core_act, exp_beat, exp_stall, exp_done;
    logic [31:0] pend_rd;
    logic [11:0] e_adr;
    logic [31:0] e_din;
    logic [3:0]  e_we;
    logic        e_ld, e_str;
    remaining = int'(len) + 1; nadr = adr; streak = 0; nbeats = 0;
    pend_rv = 1'b0; pend_rd = 32'h0; done_pend = 1'b0; finished = 1'b0; ack_cyc = 1'b1;
    budget = remaining * (STARVE_MAX + 1) + 60;
    dma_req = 1'b1; dma_wr = wr; dma_adr = adr; dma_len = len; core_ld = 1'b0; core_str = 1'b0;
    @(negedge clk);
    n_total++;
    if ({dma_ack, dma_beat, core_stall} !== 3'b000)
      $display("FAIL %s accept_cycle got ack/beat/stall=%b, want 000", tag, {dma_ack, dma_beat, core_stall});
    else n_pass++;
    @(posedge clk); #1;
    dma_wr = ~wr; dma_adr = ~adr; dma_len = 8'($urandom);
    for (int cyc = 0; cyc < budget && !finished; cyc++) begin
      case (mode)
        1:       core_act = 1'b1;
        2:       core_act = 1'($urandom_range(0, 1));
        3:       core_act = (cyc < 40);
        default: core_act = 1'b0;
      endcase
      core_ld = core_act; core_str = 1'b0; core_adr = 12'($urandom);
      core_wdata = $urandom; core_we = 4'($urandom); dma_wdata = $urandom;
      dma_req = 1'($urandom_range(0, 1));
      exp_beat  = !ack_cyc && remaining > 0 &&
                  (!core_act || (STARVE_EN && streak >= STARVE_MAX));
      exp_stall = exp_beat && core_act;
      exp_done  = done_pend;
      if (exp_beat) begin
        e_adr = nadr; e_din = wr ? dma_wdata : 32'h0; e_we = wr ? 4'hF : 4'h0;
        e_ld = !wr; e_str = wr;
      end else if (core_act) begin
        e_adr = core_adr; e_din = core_wdata; e_we = core_we; e_ld = 1'b1; e_str = 1'b0;
      end else begin
        e_adr = 12'h0; e_din = 32'h0; e_we = 4'h0; e_ld = 1'b0; e_str = 1'b0;
      end
      @(negedge clk);
      n_total++;
      if ({dma_ack, dma_beat, core_stall, dma_done, dma_rvalid} !==
          {ack_cyc, exp_beat, exp_stall, exp_done, pend_rv})
        $display("FAIL %s ctl cyc=%0d got ack/beat/stall/done/rvalid=%b, want %b", tag, cyc,
                 {dma_ack, dma_beat, core_stall, dma_done, dma_rvalid},
                 {ack_cyc, exp_beat, exp_stall, exp_done, pend_rv});
      else n_pass++;
      n_total++;
      if ({mem_adr, mem_din, mem_we, mem_ld, mem_str} !== {e_adr, e_din, e_we, e_ld, e_str})
        $display("FAIL %s mem_bus cyc=%0d got adr=%h din=%h we=%b ld=%b str=%b, want %h/%h/%b/%b/%b",
                 tag, cyc, mem_adr, mem_din, mem_we, mem_ld, mem_str, e_adr, e_din, e_we, e_ld, e_str);
      else n_pass++;
      if (pend_rv) begin
        n_total++;
        if (dma_rdata !== pend_rd)
          $display("FAIL %s rdata cyc=%0d got %h, want %h", tag, cyc, dma_rdata, pend_rd);
        else n_pass++;
      end
      if (core_act && !exp_beat) begin
        n_total++;
        if (core_rdata !== exp_word(core_adr))
          $display("FAIL %s core_rdata cyc=%0d got %h, want %h", tag, cyc, core_rdata, exp_word(core_adr));
        else n_pass++;
      end
      if (exp_done) finished = 1'b1;
      pend_rv = exp_beat && !wr;
      pend_rd = exp_word(nadr);
      if (exp_beat) begin
        if (wr) exp_write(nadr, dma_wdata, 4'hF);
        nadr = nadr + 12'd1; remaining--; streak = 0; nbeats++;
        done_pend = (remaining == 0);
      end else if (!ack_cyc && core_act && remaining > 0) begin
        streak++;
      end
      ack_cyc = 1'b0;
      @(posedge clk); #1;
    end
    n_total++;
    if (!finished || nbeats != int'(len) + 1)
      $display("FAIL %s completion got done=%0d beats=%0d, want done=1 beats=%0d (cycle budget %0d)",
               tag, finished, nbeats, int'(len) + 1, budget);
    else n_pass++;
    dma_req = 1'b0; core_ld = 1'b0;
    @(negedge clk);
    n_total++;
    if ({dma_ack, dma_beat, dma_done, dma_rvalid} !== 4'b0)
      $display("FAIL %s post_done got ack/beat/done/rvalid=%b, want 0000", tag,
               {dma_ack, dma_beat, dma_done, dma_rvalid});
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_write_burst();
    logic [11:0] a [3];
    logic [7:0]  l [3];
    run_burst(1'b1, 12'h100, 8'd3, 0, "wr_fixed");
    run_burst(1'b0, 12'h100, 8'd3, 0, "rd_fixed");
    for (int i = 0; i < 3; i++) begin
      a[i] = 12'($urandom_range(12'h200, 12'hF00));
      l[i] = 8'($urandom_range(0, 7));
      run_burst(1'b1, a[i], l[i], 2, "wr_rand");
    end
    for (int i = 0; i < 3; i++) run_burst(1'b0, a[i], l[i], 2, "rd_rand");
  endtask

  task automatic test_wrap();
    run_burst(1'b1, 12'hFFE, 8'd2, 0, "wr_wrap");
    run_burst(1'b0, 12'hFFE, 8'd2, 0, "rd_wrap");
  endtask

  task automatic test_contention();
`ifdef DMEM_ARB_STARVE_EN
    run_burst(1'b0, 12'h100, 8'd5, 1, "rd_starve");
    run_burst(1'b1, 12'h300, 8'd3, 1, "wr_starve");
`endif
    run_burst(1'b0, 12'($urandom), 8'd4, 3, "rd_core_hold");
    run_burst(1'b0, 12'h300, 8'd3, 2, "rd_core_rand");
  endtask

  task automatic test_reset_mid();
    dma_req = 1'b1; dma_wr = 1'b0; dma_adr = 12'h200; dma_len = 8'd10;
    core_ld = 1'b0; core_str = 1'b0;
    @(posedge clk); #1;
    dma_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    n_total++;
    if ({dma_beat, core_stall, mem_ld, mem_str} !== 4'b0 || mem_adr !== 12'h0)
      $display("FAIL rstmid_comb got beat/stall/ld/str=%b adr=%h, want 0000/000",
               {dma_beat, core_stall, mem_ld, mem_str}, mem_adr);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if ({dma_beat, dma_done, dma_ack, dma_rvalid, mem_ld} !== 5'b0)
        $display("FAIL rstmid_idle cyc=%0d got beat/done/ack/rvalid/ld=%b, want 00000", i,
                 {dma_beat, dma_done, dma_ack, dma_rvalid, mem_ld});
      else n_pass++;
      @(posedge clk); #1;
    end
    run_burst(1'b0, 12'h200, 8'd1, 0, "after_rst");
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_write_burst();
    test_wrap();
    test_contention();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-ported data memory between the pipeline MEM stage and a DMA/loader burst port. It sits between the Stage-4 memory signals (address, store data, byte write-enables, ld/str) and `datamemory`. The core has priority, and a starvation counter guarantees DMA progress. The block asserts `core_stall` when it takes a memory cycle away from an active core access.

## Interface
Parameters:
- STARVE_MAX, 8: consecutive DMA-blocked cycles before a DMA beat is forced (range 1..255).
- ADR_W, 12: word-address width.

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising clk.
- core_ld  in  1  MEM stage load request.
- core_str  in  1  MEM stage store request.
- core_adr  in  ADR_W  MEM stage word address.
- core_wdata  in  32  store data.
- core_we  in  4  byte write-enables.
- core_rdata  out  32  load data, combinational passthrough of mem_dout.
- core_stall  out  1  combinational; MEM stage must hold this cycle.
- dma_req  in  1  burst request, level.
- dma_wr  in  1  1 = write burst, 0 = read burst; sampled at accept.
- dma_adr  in  ADR_W  burst start word address; sampled at accept.
- dma_len  in  8  beats minus one (0 means 1 beat, 255 means 256 beats).
- dma_ack  out  1  one-cycle pulse: burst accepted.
- dma_beat  out  1  DMA owns memory this cycle; dma_wdata is consumed.
- dma_wdata  in  32  write data for the current beat.
- dma_rdata  out  32  registered read data.
- dma_rvalid  out  1  dma_rdata valid.
- dma_done  out  1  one-cycle pulse after the last beat.
- mem_adr  out  ADR_W  to datamemory.
- mem_din  out  32  to datamemory.
- mem_we  out  4  to datamemory.
- mem_ld  out  1  to datamemory.
- mem_str  out  1  to datamemory.
- mem_dout  in  32  combinational read data from datamemory.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - The core owns memory unconditionally.
  - If dma_req=1, pulse dma_ack, latch dma_adr, dma_len and dma_wr, clear starve_cnt, and go to RUN.
- RUN, each cycle:
  - The core is active when core_ld or core_str is 1.
  - If the core is active and starve_cnt < STARVE_MAX:
    - The core is granted.
    - starve_cnt increments.
    - core_stall=0.
  - Otherwise, the DMA is granted:
    - dma_beat=1.
    - core_stall is set to the core-active value.
    - starve_cnt clears.
    - The address increments by 1. It wraps from 2^ADR_W−1 to 0.
    - The remaining-beat count decrements. On the last beat the FSM goes to DONE.
- DONE: dma_done=1 for one cycle, then IDLE. The core owns memory. dma_req is ignored until IDLE.
- A DMA write beat drives mem_str=1, mem_we=4'b1111 and mem_din=dma_wdata.
- A DMA read beat drives mem_ld=1. mem_dout is registered into dma_rdata, and dma_rvalid=1 on the next cycle.
- A core grant drives the mem_* outputs straight from the core_* inputs.
- No grant: all mem_* outputs are 0.
- dma_req while in RUN or DONE: no effect, no dma_ack.

## Timing
- Reset values: state=IDLE, starve_cnt=0, and all registered outputs 0 (dma_ack, dma_rdata, dma_rvalid, dma_done). Latched address and count are 0.
- Combinational outputs (core_stall, mem_*, dma_beat, core_rdata) are 0 while reset=0.
- The first beat can occur at the earliest one cycle after dma_ack.
- Read latency is one cycle from dma_beat to dma_rvalid.
- dma_done follows the last beat by one cycle. For a read burst it coincides with the last dma_rvalid.
- Without core traffic, a burst of N beats takes N+2 cycles from dma_ack to dma_done inclusive.
- With continuous core traffic, at least one DMA beat occurs every STARVE_MAX+1 cycles.
- A stalled core access is retried next cycle. The core wins then, because starve_cnt=0 < STARVE_MAX.
- Reset mid-burst: the burst is abandoned with no dma_done, and the state returns to IDLE the following cycle.

## Configuration
- DMEM_ARB_STARVE_EN defined: the starvation counter and forced grant are present as described.
- Not defined:
  - The DMA gets memory only in cycles with no core access.
  - core_stall is tied to 0 and STARVE_MAX is unused.
  - A DMA burst may starve indefinitely.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - ADR_W_DEF=12, DATA_W=32 and WE_FULL=4'b1111.
- One sub-module, dmem_starve_ctr: saturating counter with inc, clr and a `limit` compare output. Instantiated only under DMEM_ARB_STARVE_EN.

## Test plan
- Reset low for 2 cycles, then IDLE with core store adr=0x010, data=0xDEADBEEF, we=0011 -> mem_* mirror the core, core_stall=0, and no DMA outputs.
- DMA write burst adr=0x100, len=3, no core traffic -> dma_ack at T, beats at T+1..T+4 with adr 0x100..0x103 and we=1111, dma_done at T+5.
- Core loads every cycle during a read burst, STARVE_MAX=8 -> 8 core grants, then one DMA beat with core_stall=1, repeating. dma_rvalid follows each beat by 1 cycle with the memory contents.
- Burst at adr=0xFFE, len=2 -> beat addresses 0xFFE, 0xFFF, 0x000.
- reset=0 in the middle of a len=10 burst -> next cycle state IDLE, no dma_done. A new dma_req is then accepted normally.
- Build without DMEM_ARB_STARVE_EN, continuous core traffic -> zero DMA beats and core_stall never asserted. Dropping core traffic then lets the burst complete.
